// File: rtl/motion_pkg.sv
// Shared types, defaults and the saturation helper for the motion controller.
package motion_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StConv,
        StWait,
        StNext,
        StCtrl,
        StDone
    } state_e;

    localparam int unsigned P_SHIFT_DEF = 2;
    localparam int unsigned I_SHIFT_DEF = 6;
    localparam int unsigned I_MAX_DEF   = 255;
    localparam int          BASE_DEF    = 512;

    function automatic logic signed [31:0] sat_clip(input logic signed [31:0] v,
                                                    input int lo, input int hi);
        logic signed [31:0] r;
        r = v;
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/motion_ctrl_n_sat_add.sv
// Signed add/subtract of two W-bit operands, clamped to [LO, HI] and narrowed to OW bits.
module motion_sat_add
    import motion_pkg::*;
#(
    parameter int unsigned W   = 16,
    parameter int unsigned OW  = 16,
    parameter int          LO  = -255,
    parameter int          HI  = 255,
    parameter bit          SUB = 1'b0
) (
    input  logic signed [W-1:0]  i_a,
    input  logic signed [W-1:0]  i_b,
    output logic signed [OW-1:0] o_sum
);

    logic signed [W:0]  w_a;
    logic signed [W:0]  w_b;
    logic signed [W:0]  w_sum;
    logic signed [31:0] w_wide;

    // One guard bit makes the raw sum exact before clamping.
    assign w_a    = {i_a[W-1], i_a};
    assign w_b    = {i_b[W-1], i_b};
    assign w_sum  = SUB ? (w_a - w_b) : (w_a + w_b);
    assign w_wide = {{(31 - W){w_sum[W]}}, w_sum};
    assign o_sum  = OW'(sat_clip(w_wide, LO, HI));

endmodule

// File: rtl/motion_ctrl_n.sv
// IR sensor-pair sequencer with a PI steering controller: reads right/left pairs through a
// shared A2D, accumulates a weighted error and produces saturated left/right motor commands.
module motion_ctrl_n
    import motion_pkg::*;
#(
    parameter int unsigned NUM_PAIRS  = 3,
    parameter int unsigned A2D_W      = 12,
    parameter int unsigned OUT_W      = 11,
    parameter int unsigned SETTLE_CYC = 4096,
    parameter int unsigned TMO_CYC    = 65535,
    parameter int unsigned P_SHIFT    = P_SHIFT_DEF,
    parameter int unsigned I_SHIFT    = I_SHIFT_DEF,
    parameter int unsigned I_MAX      = I_MAX_DEF,
    parameter int          BASE       = BASE_DEF,
    localparam int unsigned CH_W      = $clog2(2 * NUM_PAIRS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    go,
    input  logic                    cnv_cmplt,
    input  logic [A2D_W-1:0]        A2D_res,
    output logic                    start_conv,
    output logic [CH_W-1:0]         chnnl,
    output logic [NUM_PAIRS-1:0]    IR_en,
    output logic signed [OUT_W-1:0] lft,
    output logic signed [OUT_W-1:0] rht,
    output logic                    busy,
    output logic                    done,
    output logic                    tmo_err,
    output logic [7:0]              LEDs
);

    localparam int unsigned EW = A2D_W + NUM_PAIRS + 1;
    localparam int unsigned KW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned TW = $clog2(TMO_CYC + 1);
    localparam int          OUT_MAX = (32'sd1 <<< (OUT_W - 1)) - 1;
    localparam int          OUT_MIN = -(32'sd1 <<< (OUT_W - 1));
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TMO_CYC - 1);
    localparam logic [KW-1:0] K_LAST      = KW'(NUM_PAIRS - 1);

    state_e                r_state;
    logic [KW-1:0]         r_k;
    logic                  r_side;
    logic [SW-1:0]         r_settle;
    logic [TW-1:0]         r_tmo;
    logic [A2D_W-1:0]      r_right;
    logic signed [EW-1:0]  r_err;
    logic signed [EW-1:0]  r_integ;

    logic [CH_W-1:0]       w_ch;
    logic signed [EW-1:0]  w_r;
    logic signed [EW-1:0]  w_l;
    logic signed [EW-1:0]  w_term;
    logic signed [EW-1:0]  w_err_i;
    logic signed [EW-1:0]  w_err_p;
    logic signed [EW-1:0]  w_integ;
    logic signed [EW:0]    w_pe;
    logic signed [EW:0]    w_ie;
    logic signed [EW:0]    w_corr;
    logic signed [EW:0]    w_base;
    logic signed [OUT_W-1:0] w_lft;
    logic signed [OUT_W-1:0] w_rht;

    assign w_ch    = CH_W'({r_k, r_side});
    assign w_r     = EW'(r_right);
    assign w_l     = EW'(A2D_res);
    // Farther pairs get a larger lever arm in the error sum.
    assign w_term  = (w_r - w_l) <<< r_k;
    assign w_err_i = r_err >>> I_SHIFT;
    assign w_err_p = r_err >>> P_SHIFT;
    assign w_pe    = {w_err_p[EW-1], w_err_p};
    assign w_ie    = {w_integ[EW-1], w_integ};
    assign w_corr  = w_pe + w_ie;
    assign w_base  = (EW + 1)'(BASE);

    motion_sat_add #(
        .W   (EW),
        .OW  (EW),
        .LO  (-int'(I_MAX)),
        .HI  (int'(I_MAX)),
        .SUB (1'b0)
    ) u_integ (
        .i_a   (r_integ),
        .i_b   (w_err_i),
        .o_sum (w_integ)
    );

    motion_sat_add #(
        .W   (EW + 1),
        .OW  (OUT_W),
        .LO  (OUT_MIN),
        .HI  (OUT_MAX),
        .SUB (1'b0)
    ) u_lft (
        .i_a   (w_base),
        .i_b   (w_corr),
        .o_sum (w_lft)
    );

    motion_sat_add #(
        .W   (EW + 1),
        .OW  (OUT_W),
        .LO  (OUT_MIN),
        .HI  (OUT_MAX),
        .SUB (1'b1)
    ) u_rht (
        .i_a   (w_base),
        .i_b   (w_corr),
        .o_sum (w_rht)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_k        <= '0;
            r_side     <= 1'b0;
            r_settle   <= '0;
            r_tmo      <= '0;
            r_right    <= '0;
            r_err      <= '0;
            r_integ    <= '0;
            start_conv <= 1'b0;
            chnnl      <= '0;
            IR_en      <= '0;
            lft        <= '0;
            rht        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tmo_err    <= 1'b0;
            LEDs       <= '0;
        end else begin
            start_conv <= 1'b0;
            done       <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (go) begin
                        r_k      <= '0;
                        r_err    <= '0;
                        r_settle <= '0;
                        IR_en    <= NUM_PAIRS'(1);
                        tmo_err  <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= StSettle;
                    end
                end
                StSettle: begin
                    if (r_settle == SETTLE_LAST) begin
                        r_side  <= 1'b0;
                        r_state <= StConv;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                StConv: begin
                    start_conv <= 1'b1;
                    chnnl      <= w_ch;
                    r_tmo      <= '0;
                    r_state    <= StWait;
                end
                StWait: begin
                    // A completion coincident with the request pulse belongs to no request.
                    if (cnv_cmplt && !start_conv) begin
                        if (!r_side) begin
                            r_right <= A2D_res;
                            r_side  <= 1'b1;
                            r_state <= StConv;
                        end else begin
                            r_err   <= r_err + w_term;
                            r_state <= StNext;
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        tmo_err <= 1'b1;
                        lft     <= '0;
                        rht     <= '0;
                        IR_en   <= '0;
                        busy    <= 1'b0;
                        r_state <= StIdle;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                StNext: begin
                    if (r_k == K_LAST) begin
                        IR_en   <= '0;
                        r_state <= StCtrl;
                    end else begin
                        r_k      <= r_k + 1'b1;
                        IR_en    <= NUM_PAIRS'(1) << (r_k + 1'b1);
                        r_settle <= '0;
                        r_state  <= StSettle;
                    end
                end
                StCtrl: begin
                    r_integ <= w_integ;
                    lft     <= w_lft;
                    rht     <= w_rht;
                    LEDs    <= r_err[EW-1 -: 8];
                    done    <= 1'b1;
                    r_state <= StDone;
                end
                StDone: begin
                    busy    <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_motion_ctrl_n.sv
// Randomized bench for motion_ctrl_n: an A2D responder with injected noise and a reference
// model of the error sum, PI update and output clamps, checked on every done pulse.
module tb_motion_ctrl_n;

    localparam int NP    = 3;
    localparam int CHW   = 3;
    localparam int P_SH  = 2;
    localparam int I_SH  = 6;
    localparam int IMAX  = 255;
    localparam int BASEV = 512;
    localparam int OMIN  = -1024;
    localparam int OMAX  = 1023;
    localparam int TMO   = 100;

    logic               clk;
    logic               rst;
    logic               go;
    logic               cnv_cmplt;
    logic [11:0]        A2D_res;
    logic               start_conv;
    logic [CHW-1:0]     chnnl;
    logic [NP-1:0]      IR_en;
    logic signed [10:0] lft;
    logic signed [10:0] rht;
    logic               busy;
    logic               done;
    logic               tmo_err;
    logic [7:0]         LEDs;

    int total;
    int bad;
    int done_count;
    int exp_ch;
    int m_integ;
    int pend_cnt;
    int pend_ch;
    bit noise_en;
    bit hold;
    int chan_val [2*NP];

    motion_ctrl_n #(
        .NUM_PAIRS  (NP),
        .A2D_W      (12),
        .OUT_W      (11),
        .SETTLE_CYC (8),
        .TMO_CYC    (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .cnv_cmplt  (cnv_cmplt),
        .A2D_res    (A2D_res),
        .start_conv (start_conv),
        .chnnl      (chnnl),
        .IR_en      (IR_en),
        .lft        (lft),
        .rht        (rht),
        .busy       (busy),
        .done       (done),
        .tmo_err    (tmo_err),
        .LEDs       (LEDs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Weighted right-minus-left sum over all pairs.
    function automatic int model_err();
        int e;
        e = 0;
        for (int k = 0; k < NP; k++) begin
            e += (chan_val[2*k] - chan_val[2*k+1]) * (1 << k);
        end
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset(input string name);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_done"}, int'(done), 0);
        check({name, "_start_conv"}, int'(start_conv), 0);
        check({name, "_ir_en"}, int'(IR_en), 0);
        check({name, "_chnnl"}, int'(chnnl), 0);
        check({name, "_lft"}, int'(lft), 0);
        check({name, "_rht"}, int'(rht), 0);
        check({name, "_tmo_err"}, int'(tmo_err), 0);
        check({name, "_leds"}, int'(LEDs), 0);
    endtask

    task automatic monitor();
        bit prev_busy;
        bit prev_done;
        int err;
        prev_busy = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_integ   = 0;
                exp_ch    = 0;
                prev_busy = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (busy && !prev_busy) exp_ch = 0;
                if (start_conv) begin
                    check("chnnl_seq", int'(chnnl), exp_ch);
                    check("ir_en_onehot", int'(IR_en), 1 << (exp_ch / 2));
                    exp_ch++;
                end
                if (done) begin
                    check("done_one_cycle", int'(prev_done), 0);
                    check("channels_per_cycle", exp_ch, 2 * NP);
                    check("busy_at_done", int'(busy), 1);
                    err     = model_err();
                    m_integ = clamp(m_integ + (err >>> I_SH), -IMAX, IMAX);
                    check("model_lft", int'(lft),
                          clamp(BASEV + (err >>> P_SH) + m_integ, OMIN, OMAX));
                    check("model_rht", int'(rht),
                          clamp(BASEV - ((err >>> P_SH) + m_integ), OMIN, OMAX));
                    check("model_leds", int'(LEDs), (err >>> 8) & 255);
                    done_count++;
                end
                prev_busy = busy;
                prev_done = done;
            end
        end
    endtask

    task automatic a2d();
        forever begin
            @(posedge clk);
            #1;
            cnv_cmplt = 1'b0;
            if (rst) begin
                pend_cnt = 0;
            end else if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    cnv_cmplt = 1'b1;
                    A2D_res   = 12'(chan_val[pend_ch]);
                end
            end else if (start_conv) begin
                if (!hold) begin
                    pend_ch  = int'(chnnl);
                    pend_cnt = int'($urandom_range(1, 4));
                    // Garbage completion on the request cycle must be ignored.
                    if (noise_en && $urandom_range(0, 1) == 1) begin
                        cnv_cmplt = 1'b1;
                        A2D_res   = 12'($urandom);
                    end
                end
            end else if (noise_en && !hold && $urandom_range(0, 7) == 0) begin
                cnv_cmplt = 1'b1;
                A2D_res   = 12'($urandom);
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, int'(busy), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_cycle(input string name, input bit expect_tmo_clear);
        int start;
        int n;
        start = done_count;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check({name, "_go_accepted"}, int'(busy), 1);
        if (expect_tmo_clear) check({name, "_tmo_cleared"}, int'(tmo_err), 0);
        n = 0;
        while (done_count == start && n < 3000) begin
            @(negedge clk);
            n++;
            go = noise_en && busy && ($urandom_range(0, 9) == 0);
        end
        go = 1'b0;
        check({name, "_done_seen"}, done_count - start, 1);
        wait_idle(name);
    endtask

    initial begin
        int start;
        int n;
        int b;
        int d;
        total = 0; bad = 0; done_count = 0; exp_ch = 0; m_integ = 0;
        pend_cnt = 0; pend_ch = 0; noise_en = 1'b0; hold = 1'b0;
        rst = 1'b1; go = 1'b0; cnv_cmplt = 1'b0; A2D_res = '0;
        foreach (chan_val[i]) chan_val[i] = 0;
        fork
            monitor();
            a2d();
        join_none
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // Balanced sensors with go held high: two back-to-back cycles.
        foreach (chan_val[i]) chan_val[i] = 500;
        start = done_count;
        go = 1'b1;
        n = 0;
        while (done_count < start + 2 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        go = 1'b0;
        check("held_go_cycles", done_count - start, 2);
        check("balanced_lft", int'(lft), 512);
        check("balanced_rht", int'(rht), 512);
        wait_idle("balanced");

        // Imbalance on pair 0 only.
        chan_val[0] = 1000;
        chan_val[1] = 200;
        run_cycle("pair0", 1'b0);
        check("pair0_lft", int'(lft), 724);
        check("pair0_rht", int'(rht), 300);
        check("pair0_leds", int'(LEDs), 3);

        // Full-scale imbalance with noise: integrator and outputs saturate.
        noise_en = 1'b1;
        for (int k = 0; k < NP; k++) begin
            chan_val[2*k]   = 4095;
            chan_val[2*k+1] = 0;
        end
        repeat (20) run_cycle("sat", 1'b0);
        check("sat_lft", int'(lft), 1023);
        check("sat_rht", int'(rht), -1024);
        check("sat_integ_model", m_integ, 255);

        // Random sensor patterns, half near-balanced so the integrator unwinds.
        repeat (25) begin
            b = int'($urandom_range(0, 4095));
            foreach (chan_val[i]) begin
                if ($urandom_range(0, 1) == 1) begin
                    chan_val[i] = int'($urandom_range(0, 4095));
                end else begin
                    d = int'($urandom_range(0, 64));
                    chan_val[i] = clamp(b + d - 32, 0, 4095);
                end
            end
            run_cycle("rnd", 1'b0);
        end

        // Withheld conversion: timeout path.
        noise_en = 1'b0;
        hold     = 1'b1;
        start    = done_count;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n = 0;
        while (!start_conv && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tmo_saw_start", int'(start_conv), 1);
        n = 0;
        while (!tmo_err && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("tmo_latency", n, TMO);
        check("tmo_lft", int'(lft), 0);
        check("tmo_rht", int'(rht), 0);
        check("tmo_ir_en", int'(IR_en), 0);
        check("tmo_busy", int'(busy), 0);
        repeat (5) @(negedge clk);
        check("tmo_no_done", done_count - start, 0);
        check("tmo_sticky", int'(tmo_err), 1);
        hold = 1'b0;
        chan_val[0] = 3000;
        chan_val[1] = 1000;
        run_cycle("after_tmo", 1'b1);

        // Reset while waiting on pair 1.
        foreach (chan_val[i]) chan_val[i] = int'($urandom_range(0, 4095));
        start = done_count;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n = 0;
        while (!(start_conv && int'(chnnl) == 2) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("rst_saw_pair1", int'(start_conv && int'(chnnl) == 2), 1);
        #2 rst = 1'b1;
        #1 check_reset("mid_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_no_done", done_count - start, 0);
        run_cycle("after_rst", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
